// File: rtl/gnr_node_pkg.sv
// Shared constants and helpers for the gene-regulatory-network node.
// LUT lookup, default truth tables and stable-counter width derivation.
package gnr_node_pkg;

  localparam int MAX_K = 8;

  localparam logic [3:0] GNR_LUT_OR2  = 4'b1110;
  localparam logic [3:0] GNR_LUT_AND2 = 4'b1000;
  localparam logic [3:0] GNR_LUT_XOR2 = 4'b0110;

  function automatic int sc_width(input int stable_n);
    return $clog2(stable_n + 1);
  endfunction

  // Callers zero-extend their table and index to the maximum size.
  function automatic logic lut_lookup(input logic [2**MAX_K-1:0] lut,
                                      input logic [MAX_K-1:0]    idx);
    return lut[idx];
  endfunction

endpackage

// File: rtl/gnr_node_multi_if.sv
// Control, regulator and status bundle of the multi-channel Boolean-network node.
// The master side drives stimulus and configuration; the slave side is the node.
interface gnr_node_multi_if #(
  parameter int N_CH  = 2,
  parameter int K     = 2,
  parameter int DIV_W = 4,
  parameter int CNT_W = 8
);
  logic                    reset_nos;
  logic                    init_state;
  logic [N_CH-1:0]         start;
  logic [N_CH*K-1:0]       reg_in;
  logic [N_CH*DIV_W-1:0]   cfg_div;
  logic                    lut_wr;
  logic [2**K-1:0]         lut_data;
  logic [N_CH-1:0]         s;
  logic [N_CH-1:0]         upd;
  logic [N_CH-1:0]         stable;
  logic [N_CH*CNT_W-1:0]   trans_cnt;

  modport master (
    output reset_nos, init_state, start, reg_in, cfg_div, lut_wr, lut_data,
    input  s, upd, stable, trans_cnt
  );

  modport slave (
    input  reset_nos, init_state, start, reg_in, cfg_div, lut_wr, lut_data,
    output s, upd, stable, trans_cnt
  );
endinterface

// File: rtl/gnr_node_ch.sv
// One state channel: phase divider, LUT evaluation, stable detection and
// (with GNR_NODE_TRANS_CNT_EN) a saturating transition counter.
module gnr_node_ch
  import gnr_node_pkg::*;
#(
  parameter int K        = 2,
  parameter int DIV_W    = 4,
  parameter int STABLE_N = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reset_nos,
  input  logic             init_state,
  input  logic             start,
  input  logic [K-1:0]     reg_sel,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [2**K-1:0]  lut,
  output logic             s,
  output logic             upd,
  output logic             stable,
  output logic [CNT_W-1:0] trans_cnt
);

  localparam int SC_W = sc_width(STABLE_N);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_N);

  logic [DIV_W-1:0]   ph;
  logic [DIV_W-1:0]   div_m1;
  logic [SC_W-1:0]    sc;
  logic [SC_W-1:0]    sc_nxt;
  logic               eval;
  logic               lut_val;
  logic [2**MAX_K-1:0] lut_ext;
  logic [MAX_K-1:0]   idx_ext;

  // A divider of 0 behaves like 1 (evaluate on every start).
  always_comb begin
    div_m1 = '0;
    if (cfg_div != '0) div_m1 = cfg_div - DIV_W'(1);
    eval = start && (ph >= div_m1);
  end

  always_comb begin
    lut_ext = '0;
    idx_ext = '0;
    lut_ext[2**K-1:0] = lut;
    idx_ext[K-1:0]    = reg_sel;
    lut_val = lut_lookup(lut_ext, idx_ext);
  end

  always_comb begin
    sc_nxt = '0;
    if (lut_val == s) sc_nxt = (sc == SC_MAX) ? sc : sc + SC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s      <= 1'b0;
      upd    <= 1'b0;
      stable <= 1'b0;
      ph     <= '0;
      sc     <= '0;
    end else begin
      upd <= 1'b0;
      if (reset_nos) begin
        s      <= init_state;
        ph     <= div_m1;
        sc     <= '0;
        stable <= 1'b0;
      end else if (eval) begin
        s      <= lut_val;
        ph     <= '0;
        upd    <= 1'b1;
        sc     <= sc_nxt;
        stable <= (sc_nxt == SC_MAX);
      end else if (start) begin
        ph <= ph + DIV_W'(1);
      end
    end
  end

`ifdef GNR_NODE_TRANS_CNT_EN
  logic [CNT_W-1:0] tc;

  // Survives reset_nos on purpose; only the global reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc <= '0;
    end else if (!reset_nos && eval && (lut_val != s) && (tc != '1)) begin
      tc <= tc + CNT_W'(1);
    end
  end

  assign trans_cnt = tc;
`else
  assign trans_cnt = '0;
`endif

endmodule

// File: rtl/gnr_node_multi.sv
// Multi-channel Boolean-network node: N_CH independent channels sharing one
// runtime-loadable truth table. Optional GNR_NODE_TRANS_CNT_EN adds transition counters.
module gnr_node_multi
  import gnr_node_pkg::*;
#(
  parameter int              N_CH     = 2,
  parameter int              K        = 2,
  parameter logic [2**K-1:0] LUT_INIT = GNR_LUT_OR2,
  parameter int              DIV_W    = 4,
  parameter int              STABLE_N = 4,
  parameter int              CNT_W    = 8
) (
  input logic            clk,
  input logic            rst,
  gnr_node_multi_if.slave bus
);

  logic [2**K-1:0]       lut;
  logic [N_CH-1:0]       s_w;
  logic [N_CH-1:0]       upd_w;
  logic [N_CH-1:0]       stable_w;
  logic [N_CH*CNT_W-1:0] cnt_w;

  // A write lands at the edge, so an evaluation in the same cycle sees the old table.
  always_ff @(posedge clk) begin
    if (rst)             lut <= LUT_INIT;
    else if (bus.lut_wr) lut <= bus.lut_data;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    gnr_node_ch #(
      .K        (K),
      .DIV_W    (DIV_W),
      .STABLE_N (STABLE_N),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .reset_nos  (bus.reset_nos),
      .init_state (bus.init_state),
      .start      (bus.start[c]),
      .reg_sel    (bus.reg_in[c*K +: K]),
      .cfg_div    (bus.cfg_div[c*DIV_W +: DIV_W]),
      .lut        (lut),
      .s          (s_w[c]),
      .upd        (upd_w[c]),
      .stable     (stable_w[c]),
      .trans_cnt  (cnt_w[c*CNT_W +: CNT_W])
    );
  end

  assign bus.s         = s_w;
  assign bus.upd       = upd_w;
  assign bus.stable    = stable_w;
  assign bus.trans_cnt = cnt_w;

endmodule
